// File: rtl/timer_peripheral_pkg.sv
// Data-bus memory map and register layout shared by the CPU read-mux and the timer peripheral.
package timer_peripheral_pkg;

  localparam logic [31:0] TIMER_BASE_ADDR = 32'h4000_0000;

  typedef enum logic [1:0] {
    REG_TH      = 2'd0,
    REG_TL      = 2'd1,
    REG_TCON    = 2'd2,
    REG_SYSTICK = 2'd3
  } timer_reg_e;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

  // The window is 16-byte aligned, so only address bits [31:4] take part in the match.
  function automatic logic in_window(input logic [27:0] addr_page, input logic [27:0] base_page);
    return addr_page == base_page;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides clk down to a one-cycle tick every PRESCALE cycles while enabled.
module timer_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam logic [15:0] LAST_COUNT = 16'(PRESCALE - 1);

  logic [15:0] count_q;
  logic [15:0] count_d;

  // Disabling clears the count so a re-enable always waits a full period.
  always_comb begin
    count_d = count_q;
    tick    = 1'b0;
    if (!enable) begin
      count_d = '0;
    end else if (count_q == LAST_COUNT) begin
      count_d = '0;
      tick    = 1'b1;
    end else begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/timer_peripheral.sv
// Memory-mapped reload timer with sticky overflow interrupt and free-running SYSTICK,
// sitting beside DataMemory on the MEM-stage bus.
module timer_peripheral
  import timer_peripheral_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = TIMER_BASE_ADDR,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  output logic        IRQ
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [31:0] systick_q, systick_d;
  logic [2:0]  tcon_q, tcon_d;

  logic       hit;
  logic       tick;
  logic       overflow;
  logic       wr_th, wr_tl, wr_tcon;
  timer_reg_e reg_sel;
  logic       unused_addr_bits;

  assign hit              = in_window(Address[31:4], BASE_ADDR[31:4]);
  assign reg_sel          = timer_reg_e'(Address[3:2]);
  assign unused_addr_bits = ^Address[1:0];

  timer_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (tcon_q[TCON_EN]),
    .tick   (tick)
  );

  assign overflow = tick && (tl_q == 32'hFFFF_FFFF);

  always_comb begin
    wr_th   = 1'b0;
    wr_tl   = 1'b0;
    wr_tcon = 1'b0;
    if (MemWrite && hit) begin
      case (reg_sel)
        REG_TH:   wr_th   = 1'b1;
        REG_TL:   wr_tl   = 1'b1;
        REG_TCON: wr_tcon = 1'b1;
        default:  ;
      endcase
    end
  end

  // Priority: tick update first, CPU writes override it, overflow status set overrides a clear.
  always_comb begin
    th_d      = th_q;
    tl_d      = tl_q;
    tcon_d    = tcon_q;
    systick_d = systick_q + 32'd1;

    if (overflow) begin
      tl_d = th_q;
    end else if (tick) begin
      tl_d = tl_q + 32'd1;
    end

    if (wr_th) th_d = Write_data;
    if (wr_tl) tl_d = Write_data;

    if (wr_tcon) begin
      tcon_d[TCON_EN] = Write_data[TCON_EN];
      tcon_d[TCON_IE] = Write_data[TCON_IE];
      if (!Write_data[TCON_IS]) tcon_d[TCON_IS] = 1'b0;
    end

    if (overflow && tcon_q[TCON_IE]) tcon_d[TCON_IS] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_q    <= '0;
      systick_q <= '0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      systick_q <= systick_d;
    end
  end

  always_comb begin
    Read_data = 32'h0;
    if (MemRead && hit) begin
      case (reg_sel)
        REG_TH:      Read_data = th_q;
        REG_TL:      Read_data = tl_q;
        REG_TCON:    Read_data = {29'h0, tcon_q};
        REG_SYSTICK: Read_data = systick_q;
        default:     Read_data = 32'h0;
      endcase
    end
  end

  assign IRQ = tcon_q[TCON_IE] & tcon_q[TCON_IS];

endmodule

// File: tb/tb_timer_peripheral.sv
// Scoreboard bench: two timers (PRESCALE 1 and 4) on one shared bus at different bases.
module tb_timer_peripheral;

  localparam logic [31:0] BASE1       = 32'h4000_0000;
  localparam logic [31:0] BASE4       = 32'h4000_1000;
  localparam logic [31:0] OFF_TH      = 32'h0;
  localparam logic [31:0] OFF_TL      = 32'h4;
  localparam logic [31:0] OFF_TCON    = 32'h8;
  localparam logic [31:0] OFF_SYSTICK = 32'hC;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic [31:0] address = 32'h0;
  logic [31:0] writeData = 32'h0;
  logic [31:0] readData1, readData4;
  logic        irq1, irq4;
  logic [31:0] edgeCount;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] expected;
  } expect_t;

  expect_t scoreboard[$];

  always #5 clk = ~clk;

  // Independent cycle count since reset release; SYSTICK must track it exactly.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) edgeCount <= 32'd0;
    else         edgeCount <= edgeCount + 32'd1;
  end

  timer_peripheral #(
    .BASE_ADDR(BASE1),
    .PRESCALE (1)
  ) dut1 (
    .clk       (clk),
    .reset     (resetN),
    .MemRead   (memRead),
    .MemWrite  (memWrite),
    .Address   (address),
    .Write_data(writeData),
    .Read_data (readData1),
    .IRQ       (irq1)
  );

  timer_peripheral #(
    .BASE_ADDR(BASE4),
    .PRESCALE (4)
  ) dut4 (
    .clk       (clk),
    .reset     (resetN),
    .MemRead   (memRead),
    .MemWrite  (memWrite),
    .Address   (address),
    .Write_data(writeData),
    .Read_data (readData4),
    .IRQ       (irq4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic popAndCheck(input logic [31:0] actual);
    expect_t item;
    if (scoreboard.size() == 0) begin
      checkOutput("scoreboard_underflow", 32'd1, 32'd0);
    end else begin
      item = scoreboard.pop_front();
      checkOutput(item.tag, actual, item.expected);
    end
  endtask

  // Called just after a negedge; the write lands on the following posedge.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
    memWrite  = 1'b1;
    address   = addr;
    writeData = data;
    @(negedge clk);
    memWrite  = 1'b0;
  endtask

  task automatic sampleRead(input logic [31:0] addr, input string tag, input logic [31:0] expected);
    scoreboard.push_back('{tag, expected});
    memRead = 1'b1;
    address = addr;
    #1;
    popAndCheck(addr[12] ? readData4 : readData1);
    memRead = 1'b0;
  endtask

  task automatic sampleIrq(input logic sel4, input string tag, input logic expected);
    scoreboard.push_back('{tag, {31'h0, expected}});
    #1;
    popAndCheck({31'h0, sel4 ? irq4 : irq1});
  endtask

  initial begin
    #1;
    sampleRead(BASE1 + OFF_TH,      "rst_th",      32'h0);
    sampleRead(BASE1 + OFF_TL,      "rst_tl",      32'h0);
    sampleRead(BASE1 + OFF_TCON,    "rst_tcon",    32'h0);
    sampleIrq(1'b0, "rst_irq", 1'b0);

    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    sampleRead(BASE1 + OFF_SYSTICK, "release_systick", 32'd1);
    sampleRead(BASE1 + OFF_TL,      "release_tl",      32'h0);
    sampleRead(BASE1 + OFF_TCON,    "release_tcon",    32'h0);

    // Reload/overflow sequence at PRESCALE=1
    applyStimulus(BASE1 + OFF_TH, 32'hFFFF_FFFC);
    applyStimulus(BASE1 + OFF_TL, 32'hFFFF_FFFE);
    applyStimulus(BASE1 + OFF_TCON, 32'h3);
    sampleRead(BASE1 + OFF_TL,   "enable_edge_tl", 32'hFFFF_FFFE);
    sampleRead(BASE1 + OFF_TCON, "enable_tcon",    32'h3);
    @(negedge clk);
    sampleRead(BASE1 + OFF_TL, "first_tick_tl", 32'hFFFF_FFFF);
    @(negedge clk);
    sampleRead(BASE1 + OFF_TL,   "overflow_reload_tl", 32'hFFFF_FFFC);
    sampleRead(BASE1 + OFF_TCON, "overflow_tcon",      32'h7);
    sampleIrq(1'b0, "overflow_irq", 1'b1);

    // Keeping status set vs clearing it
    applyStimulus(BASE1 + OFF_TCON, 32'h7);
    sampleIrq(1'b0, "keep_status_irq", 1'b1);
    sampleRead(BASE1 + OFF_TL, "keep_status_tl", 32'hFFFF_FFFD);
    applyStimulus(BASE1 + OFF_TCON, 32'h1);
    sampleIrq(1'b0, "clear_irq", 1'b0);
    sampleRead(BASE1 + OFF_TCON, "clear_tcon", 32'h1);
    sampleRead(BASE1 + OFF_TL,   "clear_still_counting", 32'hFFFF_FFFE);
    @(negedge clk);
    @(negedge clk);
    sampleRead(BASE1 + OFF_TL,   "no_ie_reload_tl", 32'hFFFF_FFFC);
    sampleRead(BASE1 + OFF_TCON, "no_ie_tcon",      32'h1);

    applyStimulus(BASE1 + OFF_TCON, 32'h3);
    repeat (3) @(negedge clk);
    sampleRead(BASE1 + OFF_TCON, "ie_overflow_tcon", 32'h7);
    sampleIrq(1'b0, "ie_overflow_irq", 1'b1);
    repeat (3) @(negedge clk);
    sampleRead(BASE1 + OFF_TL, "pre_collide_tl", 32'hFFFF_FFFF);
    applyStimulus(BASE1 + OFF_TCON, 32'h3);
    sampleRead(BASE1 + OFF_TCON, "set_beats_clear_tcon", 32'h7);
    sampleRead(BASE1 + OFF_TL,   "set_beats_clear_tl",   32'hFFFF_FFFC);

    // TH written on the overflow edge: reload takes the old TH
    repeat (3) @(negedge clk);
    applyStimulus(BASE1 + OFF_TH, 32'h1111_1111);
    sampleRead(BASE1 + OFF_TL,       "old_th_reload_tl", 32'hFFFF_FFFC);
    sampleRead(BASE1 + OFF_TH,       "new_th",           32'h1111_1111);
    sampleRead(BASE1 + 32'h3,        "low_addr_bits_ignored", 32'h1111_1111);

    applyStimulus(BASE1 + OFF_TL, 32'h1234_5678);
    sampleRead(BASE1 + OFF_TL, "tl_write_beats_tick", 32'h1234_5678);
    @(negedge clk);
    sampleRead(BASE1 + OFF_TL, "tl_after_write_tick", 32'h1234_5679);

    applyStimulus(BASE1 + OFF_TCON, 32'h3);
    sampleRead(BASE1 + OFF_TCON, "plain_clear_tcon", 32'h3);
    sampleIrq(1'b0, "plain_clear_irq", 1'b0);

    sampleRead(BASE1 + OFF_SYSTICK, "systick_a", edgeCount);
    repeat (10) @(negedge clk);
    sampleRead(BASE1 + OFF_SYSTICK, "systick_b", edgeCount);
    sampleRead(BASE1 + 32'h10, "outside_window_read", 32'h0);
    applyStimulus(BASE1 + 32'h10, 32'hDEAD_BEEF);
    sampleRead(BASE1 + OFF_TH, "outside_window_write", 32'h1111_1111);
    applyStimulus(BASE1 + OFF_SYSTICK, 32'h0);
    sampleRead(BASE1 + OFF_SYSTICK, "systick_write_ignored", edgeCount);

    // Disabled timer holds; simultaneous read+write returns pre-edge data
    applyStimulus(BASE1 + OFF_TCON, 32'h0);
    applyStimulus(BASE1 + OFF_TL, 32'h55);
    @(negedge clk);
    sampleRead(BASE1 + OFF_TL, "disabled_hold_tl", 32'h55);
    scoreboard.push_back('{"rw_pre_edge", 32'h55});
    memRead   = 1'b1;
    memWrite  = 1'b1;
    address   = BASE1 + OFF_TL;
    writeData = 32'hAAAA_0000;
    #1;
    popAndCheck(readData1);
    @(negedge clk);
    memRead  = 1'b0;
    memWrite = 1'b0;
    sampleRead(BASE1 + OFF_TL, "rw_post_edge", 32'hAAAA_0000);

    // PRESCALE=4 timer, including disable/re-enable restart
    applyStimulus(BASE4 + OFF_TCON, 32'h1);
    repeat (3) @(negedge clk);
    sampleRead(BASE4 + OFF_TL, "ps4_before_first", 32'h0);
    @(negedge clk);
    sampleRead(BASE4 + OFF_TL, "ps4_first_tick", 32'h1);
    repeat (3) @(negedge clk);
    sampleRead(BASE4 + OFF_TL, "ps4_before_second", 32'h1);
    @(negedge clk);
    sampleRead(BASE4 + OFF_TL, "ps4_second_tick", 32'h2);
    repeat (2) @(negedge clk);
    applyStimulus(BASE4 + OFF_TCON, 32'h0);
    applyStimulus(BASE4 + OFF_TCON, 32'h1);
    repeat (3) @(negedge clk);
    sampleRead(BASE4 + OFF_TL, "ps4_restart_wait", 32'h2);
    @(negedge clk);
    sampleRead(BASE4 + OFF_TL, "ps4_restart_tick", 32'h3);

    // Asynchronous reset with IRQ pending
    applyStimulus(BASE1 + OFF_TL, 32'hFFFF_FFFF);
    applyStimulus(BASE1 + OFF_TCON, 32'h3);
    @(negedge clk);
    sampleIrq(1'b0, "pre_reset_irq", 1'b1);
    resetN = 1'b0;
    sampleIrq(1'b0, "async_reset_irq", 1'b0);
    sampleRead(BASE1 + OFF_TH,      "async_reset_th",      32'h0);
    sampleRead(BASE1 + OFF_TL,      "async_reset_tl",      32'h0);
    sampleRead(BASE1 + OFF_TCON,    "async_reset_tcon",    32'h0);
    sampleRead(BASE1 + OFF_SYSTICK, "async_reset_systick", 32'h0);
    sampleRead(BASE4 + OFF_TL,      "async_reset_tl4",     32'h0);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    sampleRead(BASE1 + OFF_SYSTICK, "rerelease_systick", 32'd1);
    repeat (3) @(negedge clk);
    sampleRead(BASE1 + OFF_TL,   "no_resume_tl",   32'h0);
    sampleRead(BASE1 + OFF_TCON, "no_resume_tcon", 32'h0);
    sampleRead(BASE4 + OFF_TL,   "no_resume_tl4",  32'h0);

    checkOutput("scoreboard_drained", 32'(scoreboard.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
